// File: rtl/hazard_control_pkg.sv
// Shared pipeline definitions for the hazard/stall controller:
// register-address width, the hardwired zero register and the FSM state encoding.
package hazard_control_pkg;

    localparam int REG_ADDR_W = 5;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        RUN       = 1'b0,
        MULT_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational hazard detection: load-use and branch-operand
// dependencies of the ID instruction against the EX and MEM instructions.
module hazard_detect
    import hazard_control_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  id_branch_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_reg_write_i,
    input  logic [REG_ADDR_W-1:0] ex_dest_i,
    input  logic                  mem_mem_read_i,
    input  logic [REG_ADDR_W-1:0] mem_dest_i,
    output logic                  load_use_o,
    output logic                  br_dep_o
);

    logic ex_match;
    logic mem_match;

    // A destination matches when it is a real register read by the ID instruction.
    always_comb begin
        ex_match  = (ex_dest_i != ZERO_REG) &&
                    ((ex_dest_i == id_rs_i) || (id_uses_rt_i && (ex_dest_i == id_rt_i)));
        mem_match = (mem_dest_i != ZERO_REG) &&
                    ((mem_dest_i == id_rs_i) || (id_uses_rt_i && (mem_dest_i == id_rt_i)));
    end

    // Branches resolve in ID, so they need any EX result and any MEM load result;
    // other instructions only wait on a load still in EX (forwarding covers the rest).
    always_comb begin
        load_use_o = ex_mem_read_i && ex_match;
        br_dep_o   = id_branch_i && ((ex_reg_write_i && ex_match) ||
                                     (mem_mem_read_i && mem_match));
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard and stall controller. Produces the PC write enable and the
// IF/ID / ID/EX controls, and holds the pipeline for a multi-cycle multiply.
// Optional feature: define HAZARD_STALL_COUNT_EN to add a saturating 16-bit
// count of cycles in which the PC was held (output stall_cycles).
module hazard_control
    import hazard_control_pkg::*;
#(
    parameter int MULT_LATENCY = 4,
    parameter int CNT_W        = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_branch,
    input  logic                  id_mult,
    input  logic                  branch_taken,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  mem_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  mult_busy
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic             load_use, br_dep, stall, take;

    hazard_detect u_detect (
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rt_i   (id_uses_rt),
        .id_branch_i    (id_branch),
        .ex_mem_read_i  (ex_mem_read),
        .ex_reg_write_i (ex_reg_write),
        .ex_dest_i      (ex_dest),
        .mem_mem_read_i (mem_mem_read),
        .mem_dest_i     (mem_dest),
        .load_use_o     (load_use),
        .br_dep_o       (br_dep)
    );

    assign stall = load_use || br_dep;
    assign take  = id_branch && branch_taken;

    // Next state: a multiply issues only in a cycle that would otherwise run
    // normally; the counter then yields MULT_LATENCY-1 hold cycles.
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        case (state_q)
            RUN: begin
                if (!stall && !take && id_mult) begin
                    state_d = MULT_WAIT;
                    mcnt_d  = CNT_W'(MULT_LATENCY - 1);
                end
            end
            MULT_WAIT: begin
                if (mcnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                    mcnt_d  = '0;
                end else begin
                    mcnt_d = mcnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                mcnt_d  = '0;
            end
        endcase
    end

    // State and multiply counter; reset aborts any multiply wait at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    // Mealy outputs in priority order so a stall acts in the cycle it appears.
    always_comb begin
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        mult_busy    = 1'b0;
        if (reset) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state_q == MULT_WAIT) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            id_ex_bubble = 1'b1;
            mult_busy    = 1'b1;
        end else if (stall) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (take) begin
            if_id_flush  = 1'b1;
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (!PCWrite && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed scenarios plus a random
// run compared against a cycle-level behavioural model.
module tb_hazard_control;

    localparam int L  = 4;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs, id_rt, ex_dest, mem_dest;
    logic          id_uses_rt, id_branch, id_mult, branch_taken;
    logic          ex_mem_read, ex_reg_write, mem_mem_read;
    logic          PCWrite, IFIDWrite, if_id_flush, id_ex_bubble, mult_busy;
`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0]   stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: remaining multiply hold cycles and expected stall count.
    int          busy_left = 0;
    int unsigned exp_cnt   = 0;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic flush;
        logic bubble;
        logic busy;
    } out_t;

    hazard_control #(.MULT_LATENCY(L), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_branch    (id_branch),
        .id_mult      (id_mult),
        .branch_taken (branch_taken),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_dest      (ex_dest),
        .mem_mem_read (mem_mem_read),
        .mem_dest     (mem_dest),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .mult_busy    (mult_busy)
`ifdef HAZARD_STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic hit(input logic [AW-1:0] d);
        return (d != 0) && ((d == id_rs) || (id_uses_rt && (d == id_rt)));
    endfunction

    function automatic out_t model_out();
        out_t e;
        logic st;
        st = (ex_mem_read && hit(ex_dest)) ||
             (id_branch && ((ex_reg_write && hit(ex_dest)) || (mem_mem_read && hit(mem_dest))));
        if (reset)                         e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        else if (busy_left > 0)            e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        else if (st)                       e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        else if (id_branch && branch_taken) e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        else                               e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        return e;
    endfunction

    function automatic out_t dut_out();
        return '{PCWrite, IFIDWrite, if_id_flush, id_ex_bubble, mult_busy};
    endfunction

    // Advance the model with the inputs seen at the coming edge, then cross it.
    task automatic tick();
        out_t e;
        e = model_out();
        if (reset) begin
            busy_left = 0;
            exp_cnt   = 0;
        end else begin
            if (!e.pc && exp_cnt < 32'd65535) exp_cnt++;
            if (busy_left > 0) busy_left--;
            else if (e.pc && !e.flush && id_mult) busy_left = L - 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_dest = '0; mem_dest = '0;
        id_uses_rt = 0; id_branch = 0; id_mult = 0; branch_taken = 0;
        ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (PCWrite !== 1'b0)      begin n_fail++; $display("FAIL reset_pc got %b want 0", PCWrite); end
        n_checks++; if (IFIDWrite !== 1'b0)    begin n_fail++; $display("FAIL reset_ifid got %b want 0", IFIDWrite); end
        n_checks++; if (if_id_flush !== 1'b1)  begin n_fail++; $display("FAIL reset_flush got %b want 1", if_id_flush); end
        n_checks++; if (id_ex_bubble !== 1'b1) begin n_fail++; $display("FAIL reset_bubble got %b want 1", id_ex_bubble); end
        n_checks++; if (mult_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", mult_busy); end
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_load_use();
        idle(); ex_mem_read = 1; ex_dest = 5; id_rs = 5;
        #3;
        n_checks++; if ({PCWrite, IFIDWrite, id_ex_bubble} !== 3'b001)
            begin n_fail++; $display("FAIL load_use got pc/ifid/bub=%b want 001", {PCWrite, IFIDWrite, id_ex_bubble}); end
        tick();
        idle(); mem_mem_read = 1; mem_dest = 5; id_rs = 5;
        #3;
        n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL load_use_next_pc got %b want 1", PCWrite); end
        tick();
    endtask

    task automatic test_reg_zero();
        idle(); ex_mem_read = 1; ex_dest = 0; id_rs = 0;
        #3;
        n_checks++; if ({PCWrite, id_ex_bubble} !== 2'b10)
            begin n_fail++; $display("FAIL reg_zero got pc/bub=%b want 10", {PCWrite, id_ex_bubble}); end
        tick();
    endtask

    task automatic test_branch_dep();
        idle(); id_branch = 1; ex_reg_write = 1; ex_dest = 3; id_rt = 3; id_uses_rt = 1; branch_taken = 1;
        #3;
        n_checks++; if ({PCWrite, id_ex_bubble, if_id_flush} !== 3'b010)
            begin n_fail++; $display("FAIL branch_dep got pc/bub/flush=%b want 010", {PCWrite, id_ex_bubble, if_id_flush}); end
        tick();
        ex_reg_write = 0; ex_dest = 0;
        #3;
        n_checks++; if ({if_id_flush, PCWrite} !== 2'b11)
            begin n_fail++; $display("FAIL branch_taken got flush/pc=%b want 11", {if_id_flush, PCWrite}); end
        tick();
    endtask

    task automatic test_mult();
        idle(); id_mult = 1;
        #3;
        n_checks++; if ({PCWrite, mult_busy} !== 2'b10)
            begin n_fail++; $display("FAIL mult_issue got pc/busy=%b want 10", {PCWrite, mult_busy}); end
        tick();
        id_mult = 0;
        for (int i = 0; i < L - 1; i++) begin
            #3;
            n_checks++; if ({PCWrite, mult_busy} !== 2'b01)
                begin n_fail++; $display("FAIL mult_wait%0d got pc/busy=%b want 01", i, {PCWrite, mult_busy}); end
            tick();
        end
        #3;
        n_checks++; if ({PCWrite, mult_busy} !== 2'b10)
            begin n_fail++; $display("FAIL mult_done got pc/busy=%b want 10", {PCWrite, mult_busy}); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        idle(); id_mult = 1;
        #3; tick();
        id_mult = 0;
        #3;
        n_checks++; if (mult_busy !== 1'b1) begin n_fail++; $display("FAIL midwait_busy got %b want 1", mult_busy); end
        tick();
        #1 reset = 1;
        #1;
        n_checks++; if ({mult_busy, if_id_flush, PCWrite} !== 3'b010)
            begin n_fail++; $display("FAIL async_reset got busy/flush/pc=%b want 010", {mult_busy, if_id_flush, PCWrite}); end
        #1; tick();
        reset = 0;
        #3;
        n_checks++; if ({PCWrite, mult_busy} !== 2'b10)
            begin n_fail++; $display("FAIL after_reset got pc/busy=%b want 10", {PCWrite, mult_busy}); end
        tick();
    endtask

`ifdef HAZARD_STALL_COUNT_EN
    task automatic test_stall_count();
        idle(); reset = 1;
        #3; tick();
        reset = 0; id_mult = 1;
        tick();
        id_mult = 0;
        for (int i = 0; i < L - 1; i++) tick();
        ex_mem_read = 1; ex_dest = 5; id_rs = 5;
        tick();
        idle();
        #3;
        n_checks++; if (stall_cycles !== 16'd4) begin n_fail++; $display("FAIL stall_count got %0d want 4", stall_cycles); end
        tick();
    endtask
`endif

    task automatic test_random();
        out_t e, g;
        for (int c = 0; c < 400; c++) begin
            reset        = ($urandom_range(0, 59) == 0);
            id_rs        = AW'($urandom_range(0, 3));
            id_rt        = AW'($urandom_range(0, 3));
            ex_dest      = AW'($urandom_range(0, 3));
            mem_dest     = AW'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            id_branch    = ($urandom_range(0, 2) == 0);
            branch_taken = 1'($urandom_range(0, 1));
            id_mult      = ($urandom_range(0, 5) == 0);
            ex_mem_read  = ($urandom_range(0, 3) == 0);
            ex_reg_write = 1'($urandom_range(0, 1));
            mem_mem_read = ($urandom_range(0, 3) == 0);
            #3;
            e = model_out();
            g = dut_out();
            n_checks++; if (g !== e)
                begin n_fail++; $display("FAIL random_c%0d got pc/ifid/flush/bub/busy=%b want %b", c, g, e); end
`ifdef HAZARD_STALL_COUNT_EN
            n_checks++; if (stall_cycles !== 16'(exp_cnt))
                begin n_fail++; $display("FAIL random_cnt_c%0d got %0d want %0d", c, stall_cycles, exp_cnt); end
`endif
            tick();
        end
        reset = 0;
        idle();
        tick();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_load_use();
        test_reg_zero();
        test_branch_dep();
        test_mult();
        test_reset_mid_wait();
`ifdef HAZARD_STALL_COUNT_EN
        test_stall_count();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Pipeline hazard and stall controller; drives the program counter's `PCWrite` enable and the IF/ID and ID/EX pipeline controls.
- It is the producer side of the PC write-enable interface: it decides each cycle whether the PC loads its next value or holds.
- Detects load-use hazards, branch operand hazards (branches resolve in ID) and taken branches.
- Sequences a multi-cycle multiplier stall with an internal FSM and down-counter.

Parameters:
- `MULT_LATENCY`, 4, total cycles the multiplier occupies EX; legal 2..16.
- `REG_ADDR_W`, 5, register-file address width.
- `CNT_W`, 4, width of the multiplier down-counter; must hold `MULT_LATENCY-1`.

Ports:
- `clock` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `id_rs` input `REG_ADDR_W`: rs field of the instruction in ID.
- `id_rt` input `REG_ADDR_W`: rt field of the instruction in ID.
- `id_uses_rt` input 1: the ID instruction reads rt as a source.
- `id_branch` input 1: the ID instruction is a conditional branch.
- `id_mult` input 1: the ID instruction is a multiply.
- `branch_taken` input 1: branch comparator result in ID; valid only when `id_branch`=1.
- `ex_mem_read` input 1: the EX instruction is a load.
- `ex_reg_write` input 1: the EX instruction writes a register.
- `ex_dest` input `REG_ADDR_W`: destination register of the EX instruction.
- `mem_mem_read` input 1: the MEM instruction is a load.
- `mem_dest` input `REG_ADDR_W`: destination register of the MEM instruction.
- `PCWrite` output 1: PC load enable; 0 holds the PC.
- `IFIDWrite` output 1: IF/ID register load enable.
- `if_id_flush` output 1: replace the IF/ID contents with a NOP.
- `id_ex_bubble` output 1: zero the ID/EX control fields.
- `mult_busy` output 1: multiplier occupies EX.

Behaviour:
- State register values: `RUN`, `MULT_WAIT`. Down-counter `mcnt` is `CNT_W` bits wide.
- Everything except the state and counter is Mealy-combinational from the state plus the ID/EX/MEM inputs, so a stall takes effect in the same cycle the hazard is visible.
- Reset (asynchronous, active-high):
  - state=`RUN`, `mcnt`=0.
  - While `reset`=1: `PCWrite`=0, `IFIDWrite`=0, `if_id_flush`=1, `id_ex_bubble`=1, `mult_busy`=0.
  - Reset asserted during `MULT_WAIT` aborts the wait immediately.
- Hazard terms (register 0 never matches):
  - `match(d)` = `d`!=0 && (`d`==`id_rs` || (`id_uses_rt` && `d`==`id_rt`)).
  - `load_use` = `ex_mem_read` && `match(ex_dest)`.
  - `br_dep` = `id_branch` && ((`ex_reg_write` && `match(ex_dest)`) || (`mem_mem_read` && `match(mem_dest)`)).
  - `stall` = `load_use` || `br_dep`.
- Priority per cycle, highest first:
  1. `MULT_WAIT`: `PCWrite`=0, `IFIDWrite`=0, `id_ex_bubble`=1, `mult_busy`=1. All other inputs are ignored.
  2. `stall`: `PCWrite`=0, `IFIDWrite`=0, `id_ex_bubble`=1, `if_id_flush`=0. `branch_taken` is ignored.
  3. `id_branch` && `branch_taken`: `PCWrite`=1, `IFIDWrite`=1, `if_id_flush`=1, `id_ex_bubble`=0.
  4. `id_mult`: outputs as normal run. On the clock edge: state→`MULT_WAIT`, `mcnt`=`MULT_LATENCY`-1.
  5. Otherwise: `PCWrite`=1, `IFIDWrite`=1, `if_id_flush`=0, `id_ex_bubble`=0.
- In `MULT_WAIT`, `mcnt` decrements each cycle. When `mcnt`==1, the next state is `RUN` and `mcnt` becomes 0.
- Result: exactly `MULT_LATENCY`-1 stall cycles after the multiply issues.
- A multiply with a pending `stall` does not start; it issues once the stall clears.
- Load-use then branch dependency on the same load gives two consecutive stall cycles: the first from EX, the second from MEM.
- `mult_busy` is 0 in `RUN`.

Optional Feature:
- Macro `HAZARD_STALL_COUNT_EN`.
- When defined:
  - Adds output `stall_cycles` [15:0].
  - Counts every cycle with `PCWrite`=0 while `reset`=0.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by `reset`.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - state encoding constants `RUN`/`MULT_WAIT`;
  - `REG_ADDR_W`;
  - the zero-register constant.
- Sub-module `hazard_detect`: purely combinational `load_use`/`br_dep` evaluation, instantiated once.
- The FSM, counter and output priority logic stay in `hazard_control`.

Test Plan:
- Load-use:
  - Stimulus: `ex_mem_read`=1, `ex_dest`=5, `id_rs`=5.
  - Response: `PCWrite`=0, `IFIDWrite`=0, `id_ex_bubble`=1 for that cycle.
  - Next cycle, with the load moved to MEM and `id_branch`=0: `PCWrite`=1.
- Register-zero immunity:
  - Stimulus: `ex_mem_read`=1, `ex_dest`=0, `id_rs`=0.
  - Response: no stall, `PCWrite`=1.
- Branch dependency:
  - Stimulus: `id_branch`=1, `ex_reg_write`=1, `ex_dest`=3, `id_rt`=3, `id_uses_rt`=1, `branch_taken`=1.
  - Response: stall, `if_id_flush`=0.
  - Next cycle with no dependency and `branch_taken`=1: `if_id_flush`=1, `PCWrite`=1.
- Multiply, `MULT_LATENCY`=4:
  - Stimulus: `id_mult` pulse.
  - Response: issue cycle runs normally, then exactly 3 cycles with `mult_busy`=1 and `PCWrite`=0, then `RUN`.
- Reset mid-wait:
  - Stimulus: assert `reset` asynchronously during the 2nd `MULT_WAIT` cycle.
  - Response: immediately `mult_busy`=0, `if_id_flush`=1; after release, `PCWrite`=1.
- Stall counter, `HAZARD_STALL_COUNT_EN` defined:
  - Stimulus: the multiply scenario above plus one load-use stall.
  - Response: `stall_cycles`=4.
